// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the 800x600 VGA timing generator: walks the active area,
// reads a 2^SHIFT down-scaled frame buffer and re-aligns pixels with delayed strobes.
module vga_pixel_fetch #(
    parameter int H_ACT  = 800,
    parameter int V_ACT  = 600,
    parameter int SHIFT  = 2,
    parameter int FB_W   = 200,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1,
    parameter int RGB_W  = 12
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              hen,
    input  logic              ven,
    input  logic              hs,
    input  logic              vs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [RGB_W-1:0]  rd_data,
    output logic [RGB_W-1:0]  rgb,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic              frame_start
);

    localparam int L = RD_LAT + 2;

    logic              sync_ok;
    logic              hen_d;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [9:0]        y_inc;
    logic [ADDR_W-1:0] row_base;
    logic              de_in;
    logic              first_px;
    logic              line_end;
    logic [L-1:0]      hs_sr;
    logic [L-1:0]      vs_sr;
    logic [L-1:0]      de_sr;
    logic [L-1:0]      fs_sr;

    assign de_in    = hen & ven & sync_ok;
    assign first_px = de_in & (x == '0) & (y == '0);
    assign line_end = hen_d & ~hen & ven & sync_ok;
    assign y_inc    = y + 10'd1;

    // sync_ok only rises after a vertical blank, so a frame cut by reset is never fetched
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_ok <= 1'b0;
            hen_d   <= 1'b0;
        end else begin
            hen_d <= hen;
            if (!ven)
                sync_ok <= 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst || !hen)
            x <= '0;
        else if (de_in && (x != 10'(H_ACT - 1)))
            x <= x + 10'd1;
    end

    // row_base steps by one stored row every 2^SHIFT screen lines instead of multiplying
    always_ff @(posedge pclk) begin
        if (rst || !ven) begin
            y        <= '0;
            row_base <= '0;
        end else if (line_end && (y != 10'(V_ACT - 1))) begin
            y <= y_inc;
            if (y_inc[SHIFT-1:0] == '0)
                row_base <= row_base + ADDR_W'(FB_W);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst)
            rd_addr <= '0;
        else if (de_in)
            rd_addr <= row_base + ADDR_W'(x >> SHIFT);
        else
            rd_addr <= '0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hs_sr <= '0;
            vs_sr <= '0;
            de_sr <= '0;
            fs_sr <= '0;
            rgb   <= '0;
        end else begin
            hs_sr <= {hs_sr[L-2:0], hs};
            vs_sr <= {vs_sr[L-2:0], vs};
            de_sr <= {de_sr[L-2:0], de_in};
            fs_sr <= {fs_sr[L-2:0], first_px};
            rgb   <= de_sr[L-2] ? rd_data : '0;
        end
    end

    assign hs_o        = hs_sr[L-1];
    assign vs_o        = vs_sr[L-1];
    assign de_o        = de_sr[L-1];
    assign frame_start = fs_sr[L-1];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch at default parameters; a cycle-level reference
// model of the fetch behaviour scores all outputs on every clock alongside fixed vectors.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;

    logic        pclk = 1'b0;
    logic        rst;
    logic        hen;
    logic        ven;
    logic        hs;
    logic        vs;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic [11:0] rgb;
    logic        hs_o;
    logic        vs_o;
    logic        de_o;
    logic        frame_start;
    logic        fb_const = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        first;
        logic        fbc;
        logic [14:0] addr;
    } hist_t;

    hist_t       hist [3];
    int          m_x    = 0;
    int          m_y    = 0;
    logic        m_sync = 1'b0;
    logic        m_hend = 1'b0;

    int          cyc     = 0;
    int          de_cnt  = 0;
    int          fs_cnt  = 0;
    int          fs_cyc  = 0;
    int          run     = 0;
    int          max_run = 0;
    int          t_line  = 0;
    int          first_t = 0;
    int          de_mark = 0;
    int          fs_mark = 0;
    logic [14:0] rec [0:1023];

    always #5 pclk = ~pclk;

    vga_pixel_fetch dut (
        .pclk        (pclk),
        .rst         (rst),
        .hen         (hen),
        .ven         (ven),
        .hs          (hs),
        .vs          (vs),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rgb         (rgb),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .de_o        (de_o),
        .frame_start (frame_start)
    );

    function automatic logic [11:0] fbval(input logic [14:0] a);
        return a[11:0] ^ 12'hA5C;
    endfunction

    // one-cycle-latency frame buffer
    always @(posedge pclk) rd_data <= fb_const ? 12'hFFF : fbval(rd_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        hist_t       e;
        logic        de;
        logic [11:0] exp_rgb;
        de      = hen & ven & m_sync;
        e.hs    = hs;
        e.vs    = vs;
        e.de    = de;
        e.first = de && (m_x == 0) && (m_y == 0);
        e.fbc   = fb_const;
        e.addr  = de ? 15'((m_y / 4) * 200 + m_x / 4) : 15'd0;
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_x = 0; m_y = 0; m_sync = 1'b0; m_hend = 1'b0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
            if (!ven) m_y = 0;
            else if (m_hend && !hen && m_sync && m_y < 599) m_y++;
            if (!hen) m_x = 0;
            else if (de && m_x < 799) m_x++;
            if (!ven) m_sync = 1'b1;
            m_hend = hen;
        end
        @(posedge pclk);
        #1;
        cyc++;
        exp_rgb = hist[2].de ? (hist[2].fbc ? 12'hFFF : fbval(hist[2].addr)) : 12'h000;
        check("outputs", {1'b0, rd_addr, rgb, hs_o, vs_o, de_o, frame_start},
              {1'b0, hist[0].addr, exp_rgb, hist[2].hs, hist[2].vs, hist[2].de, hist[2].first});
        if (de_o) begin
            de_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (frame_start) begin
            fs_cnt++;
            fs_cyc = cyc;
        end
    endtask

    task automatic drive_line(input int act, input int blank, input logic v, input logic vsy,
                              input int rst_i);
        for (int i = 0; i < act; i++) begin
            hen = 1'b1; ven = v; vs = vsy; hs = 1'b0;
            rst = (rst_i >= 0) && (i == rst_i || i == rst_i + 1);
            if (i == 0) t_line = cyc;
            tick();
            rec[i] = rd_addr;
        end
        rst = 1'b0;
        for (int i = 0; i < blank; i++) begin
            hen = 1'b0; ven = v; vs = vsy;
            hs = (i >= blank / 4) && (i < blank / 2);
            tick();
        end
    endtask

    task automatic drive_vblank();
        for (int l = 0; l < 6; l++) drive_line(16, 8, 1'b0, (l == 1 || l == 2), -1);
    endtask

    task automatic drive_frame(input int long_y, input int stop_y, input int rst_y, input bit walk);
        logic [14:0] walk_exp [8];
        walk_exp = '{15'd0, 15'd0, 15'd0, 15'd0, 15'd1, 15'd1, 15'd1, 15'd1};
        for (int y = 0; y < stop_y; y++) begin
            if (y == long_y)              drive_line(810, 230, 1'b1, 1'b0, -1);
            else if (y == 0 || y == 599)  drive_line(800, 240, 1'b1, 1'b0, -1);
            else                          drive_line(16, 8, 1'b1, 1'b0, (y == rst_y) ? 5 : -1);
            if (y == 0) begin
                first_t = t_line;
                check("first_addr", 32'(rec[0]), 32'd0);
            end
            if (y == rst_y) de_mark = de_cnt;
            if (walk && y == 0) begin
                for (int k = 0; k < 8; k++) check("walk_y0", 32'(rec[k]), 32'(walk_exp[k]));
                check("walk_y0_x799", 32'(rec[799]), 32'd199);
            end
            if (walk && y == 3)   check("walk_y3_x0", 32'(rec[0]), 32'd0);
            if (walk && y == 4)   check("walk_y4_x0", 32'(rec[0]), 32'd200);
            if (walk && y == 599) check("walk_y599_x799", 32'(rec[799]), 32'd29999);
            if (y == long_y)
                for (int k = 799; k < 810; k++) check("long_line_hold", 32'(rec[k]), 32'd199);
            if (long_y >= 0 && y == long_y + 1) begin
                check("after_long_x0", 32'(rec[0]), 32'd200);
                check("after_long_x4", 32'(rec[4]), 32'd201);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '0;
        rst = 1'b1; hen = 1'b0; ven = 1'b0; hs = 1'b0; vs = 1'b0;

        for (int i = 0; i < 5; i++) begin
            hen = 1'($urandom); ven = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            tick();
            check("reset_outs", {1'b0, rd_addr, rgb, hs_o, vs_o, de_o, frame_start}, 32'd0);
        end
        rst = 1'b0;

        de_mark = de_cnt;
        for (int l = 0; l < 3; l++) drive_line(16, 8, 1'b1, 1'b0, -1);
        check("no_de_before_vblank", 32'(de_cnt - de_mark), 32'd0);

        drive_vblank();
        fs_mark = fs_cnt;
        max_run = 0;
        drive_frame(-1, 600, -1, 1'b1);
        check("frame1_fs_count", 32'(fs_cnt - fs_mark), 32'd1);
        check("frame1_fs_latency", 32'(fs_cyc - first_t), 32'd3);
        check("frame1_de_run", 32'(max_run), 32'd800);

        drive_vblank();
        fb_const = 1'b1;
        de_mark = de_cnt;
        drive_frame(-1, 600, -1, 1'b0);
        drive_vblank();
        check("frame2_de_cycles", 32'(de_cnt - de_mark), 32'd11168);
        fb_const = 1'b0;

        drive_frame(-1, 600, 300, 1'b0);
        check("de_after_midframe_reset", 32'(de_cnt - de_mark), 32'd0);

        drive_vblank();
        fs_mark = fs_cnt;
        drive_frame(3, 6, -1, 1'b0);
        drive_line(16, 8, 1'b1, 1'b0, -1);
        check("restart_fs_count", 32'(fs_cnt - fs_mark), 32'd1);
        check("restart_fs_latency", 32'(fs_cyc - first_t), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
